roll_generator: RTL and testbench
=================================

ROLL_GENERATOR -- requirements
Module: roll_generator

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required to accept a press or a release.
REQ-002 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; nonzero.
REQ-003 Parameter MAX_TRIES, default 16, rejection-sampling attempts before fallback.
REQ-004 clk  in  1  system clock; one clock only.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 buttonD4, buttonD6, buttonD8, buttonD10, buttonD12, buttonD20  in  1 each  raw asynchronous die-request buttons, high = pressed.
REQ-007 switchTest  in  1  deterministic test mode; every roll returns the die maximum.
REQ-008 roll_value  out  5  last roll result, 1..N.
REQ-009 roll_die  out  5  sides N of the die for roll_value: 4, 6, 8, 10, 12 or 20.
REQ-010 roll_valid  out  1  one-cycle pulse when roll_value/roll_die update.
REQ-011 busy  out  1  high in every state except IDLE.

Function
REQ-012 Each button and switchTest SHALL pass through a 2-flop synchronizer; all logic uses synced copies only.
REQ-013 A 16-bit Fibonacci LFSR with taps 16,14,13,11 SHALL advance every cycle in all states and never reach zero.
REQ-014 FSM states SHALL be IDLE, DEBOUNCE, ROLL, RELEASE.
REQ-015 IDLE: if any synced button is high, latch the highest-priority one (D4 > D6 > D8 > D10 > D12 > D20), clear the debounce counter, go to DEBOUNCE.
REQ-016 DEBOUNCE: the counter increments while the latched button stays high; if it drops, return to IDLE with no output; at DEBOUNCE_CYCLES, clear the try counter and go to ROLL.
REQ-017 Buttons other than the latched one SHALL be ignored outside IDLE.
REQ-018 ROLL candidate SHALL be the LFSR low bits masked to 2 bits (D4), 3 bits (D6, D8), 4 bits (D10, D12) or 5 bits (D20).
REQ-019 ROLL: if candidate < N, roll_value = candidate + 1; otherwise increment the try counter and re-sample next cycle.
REQ-020 On reaching MAX_TRIES rejections, the roll SHALL use fallback roll_value = candidate - N + 1 from the same cycle's candidate.
REQ-021 When synced switchTest is high on ROLL entry, roll_value SHALL be N on the first ROLL cycle.
REQ-022 On roll acceptance, roll_value, roll_die and a one-cycle roll_valid SHALL register together, then the FSM goes to RELEASE.
REQ-023 RELEASE: wait until the latched button is low for DEBOUNCE_CYCLES consecutive cycles, any high sample restarting the count, then go to IDLE.
REQ-024 roll_value and roll_die SHALL hold between rolls.
REQ-025 Latency from the synced press to roll_valid SHALL be DEBOUNCE_CYCLES + 1..MAX_TRIES ROLL cycles, 1 in test mode, plus 2 synchronizer cycles from the raw pin.

Reset
REQ-026 Reset SHALL force state IDLE, all counters 0, LFSR = LFSR_SEED, synchronizers 0, roll_value 0, roll_die 0, roll_valid 0, busy 0.
REQ-027 Reset asserted mid-roll SHALL abort the roll with no roll_valid, taking effect at the next clock edge.

Structure
REQ-028 Package dice_pkg SHALL hold the FSM state enum, die-size constants (4..20), mask widths and LFSR taps.
REQ-029 The LFSR SHALL be a sub-module lfsr16 (ports clk, reset, seed, value); the synchronizers and FSM stay inline.

Verification
REQ-030 Reset release, no buttons pressed, 100 cycles -> busy 0, roll_valid never asserted, roll_value 0.
REQ-031 switchTest=1; buttonD6 held 40 cycles -> exactly one roll_valid with roll_value 6, roll_die 6, DEBOUNCE_CYCLES+3 cycles after the raw press.
REQ-032 buttonD4 bounce of 5 cycles high then low -> no roll_valid, FSM back in IDLE.
REQ-033 buttonD20 and buttonD8 rising on the same cycle -> roll_die 8; holding D20 through RELEASE gives no second roll.
REQ-034 1000 D20 rolls with switchTest=0 -> every roll_value in 1..20, every value occurs, each roll completes within MAX_TRIES ROLL cycles.
REQ-035 reset pulsed one cycle while state is ROLL -> no roll_valid, outputs 0, next press rolls normally.

Source files
------------

// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dice_pkg
// Brief   : Shared FSM states, die sizes, candidate masks and LFSR taps.
// Rev     : 1.0
// ============================================================================
package dice_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_ROLL     = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // Order doubles as button priority: lower index wins.
   typedef enum logic [2:0] {
      SEL_D4  = 3'd0,
      SEL_D6  = 3'd1,
      SEL_D8  = 3'd2,
      SEL_D10 = 3'd3,
      SEL_D12 = 3'd4,
      SEL_D20 = 3'd5
   } die_sel_t;

   localparam logic [4:0] c_die_d4  = 5'd4;
   localparam logic [4:0] c_die_d6  = 5'd6;
   localparam logic [4:0] c_die_d8  = 5'd8;
   localparam logic [4:0] c_die_d10 = 5'd10;
   localparam logic [4:0] c_die_d12 = 5'd12;
   localparam logic [4:0] c_die_d20 = 5'd20;

   localparam int c_mask_w_d4  = 2;
   localparam int c_mask_w_d8  = 3;
   localparam int c_mask_w_d12 = 4;
   localparam int c_mask_w_d20 = 5;

   localparam logic [4:0] c_mask_d4  = 5'((1 << c_mask_w_d4) - 1);
   localparam logic [4:0] c_mask_d8  = 5'((1 << c_mask_w_d8) - 1);
   localparam logic [4:0] c_mask_d12 = 5'((1 << c_mask_w_d12) - 1);
   localparam logic [4:0] c_mask_d20 = 5'((1 << c_mask_w_d20) - 1);

   localparam int c_lfsr_tap_a = 16;
   localparam int c_lfsr_tap_b = 14;
   localparam int c_lfsr_tap_c = 13;
   localparam int c_lfsr_tap_d = 11;

   function automatic logic [4:0] die_sides(input die_sel_t sel);
      case (sel)
         SEL_D4:  die_sides = c_die_d4;
         SEL_D6:  die_sides = c_die_d6;
         SEL_D8:  die_sides = c_die_d8;
         SEL_D10: die_sides = c_die_d10;
         SEL_D12: die_sides = c_die_d12;
         default: die_sides = c_die_d20;
      endcase
   endfunction

   function automatic logic [4:0] die_mask(input die_sel_t sel);
      case (sel)
         SEL_D4:           die_mask = c_mask_d4;
         SEL_D6, SEL_D8:   die_mask = c_mask_d8;
         SEL_D10, SEL_D12: die_mask = c_mask_d12;
         default:          die_mask = c_mask_d20;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : lfsr16
// Brief   : Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
// Rev     : 1.0
// ============================================================================
module lfsr16 (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] value
);
   import dice_pkg::*;

   logic [15:0] r_lfsr;
   logic        w_fb;

   assign w_fb = r_lfsr[c_lfsr_tap_a-1] ^ r_lfsr[c_lfsr_tap_b-1]
               ^ r_lfsr[c_lfsr_tap_c-1] ^ r_lfsr[c_lfsr_tap_d-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lfsr <= seed;
      end else begin
         r_lfsr <= {r_lfsr[14:0], w_fb};
      end
   end

   assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/roll_generator.sv
`default_nettype none
// ============================================================================
// Module  : roll_generator
// Brief   : Debounced die-button roller with rejection-sampled LFSR values.
// Rev     : 1.0
// ============================================================================
module roll_generator #(
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int          MAX_TRIES       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       buttonD4,
   input  logic       buttonD6,
   input  logic       buttonD8,
   input  logic       buttonD10,
   input  logic       buttonD12,
   input  logic       buttonD20,
   input  logic       switchTest,
   output logic [4:0] roll_value,
   output logic [4:0] roll_die,
   output logic       roll_valid,
   output logic       busy
);
   import dice_pkg::*;

   localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int c_try_w = $clog2(MAX_TRIES + 1);
   localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_try_w-1:0] c_try_last = c_try_w'(MAX_TRIES - 1);

   // Bit 6 carries switchTest; bits 5:0 are the buttons in priority order.
   logic [6:0]         r_sync1, r_sync2;
   state_t             r_state, w_state_next;
   die_sel_t           r_sel, w_sel_next;
   logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
   logic [c_try_w-1:0] r_try, w_try_next;
   logic [4:0]         r_value, r_die;
   logic               r_valid;

   logic [15:0] w_lfsr, w_cand;
   logic [7:0]  w_btn_vec;
   logic [4:0]  w_sides, w_value;
   logic        w_held, w_test, w_in_range, w_accept;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .value (w_lfsr)
   );

   assign w_btn_vec  = {2'b00, r_sync2[5:0]};
   assign w_held     = w_btn_vec[r_sel];
   assign w_test     = r_sync2[6];
   assign w_sides    = die_sides(r_sel);
   assign w_cand     = w_lfsr & {11'd0, die_mask(r_sel)};
   assign w_in_range = (w_cand < {11'd0, w_sides});

   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_cnt_next   = r_cnt;
      w_try_next   = r_try;
      w_accept     = 1'b0;
      w_value      = 5'd0;
      case (r_state)
         ST_IDLE: begin
            if (|r_sync2[5:0]) begin
               if      (r_sync2[0]) w_sel_next = SEL_D4;
               else if (r_sync2[1]) w_sel_next = SEL_D6;
               else if (r_sync2[2]) w_sel_next = SEL_D8;
               else if (r_sync2[3]) w_sel_next = SEL_D10;
               else if (r_sync2[4]) w_sel_next = SEL_D12;
               else                 w_sel_next = SEL_D20;
               w_cnt_next   = '0;
               w_state_next = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (!w_held) begin
               w_state_next = ST_IDLE;
            end else if (r_cnt == c_deb_last) begin
               w_try_next   = '0;
               w_state_next = ST_ROLL;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_ROLL: begin
            if (w_test && (r_try == '0)) begin
               w_accept = 1'b1;
               w_value  = w_sides;
            end else if (w_in_range) begin
               w_accept = 1'b1;
               w_value  = w_cand[4:0] + 5'd1;
            end else if (r_try == c_try_last) begin
               // Out-of-range candidates fold back into 1..N after the last try.
               w_accept = 1'b1;
               w_value  = w_cand[4:0] - w_sides + 5'd1;
            end else begin
               w_try_next = r_try + 1'b1;
            end
            if (w_accept) begin
               w_cnt_next   = '0;
               w_state_next = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (w_held) begin
               w_cnt_next = '0;
            end else if (r_cnt == c_deb_last) begin
               w_state_next = ST_IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_state <= ST_IDLE;
         r_sel   <= SEL_D4;
         r_cnt   <= '0;
         r_try   <= '0;
         r_value <= '0;
         r_die   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_sync1 <= {switchTest, buttonD20, buttonD12, buttonD10,
                     buttonD8, buttonD6, buttonD4};
         r_sync2 <= r_sync1;
         r_state <= w_state_next;
         r_sel   <= w_sel_next;
         r_cnt   <= w_cnt_next;
         r_try   <= w_try_next;
         r_valid <= w_accept;
         if (w_accept) begin
            r_value <= w_value;
            r_die   <= w_sides;
         end
      end
   end

   assign roll_value = r_value;
   assign roll_die   = r_die;
   assign roll_valid = r_valid;
   assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_roll_generator.sv
`default_nettype none
// ============================================================================
// Module  : tb_roll_generator
// Brief   : Directed self-checking bench for roll_generator.
// Rev     : 1.0
// ============================================================================
module tb_roll_generator;

   localparam int DEB   = 16;
   localparam int TRIES = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bD4 = 1'b0, bD6 = 1'b0, bD8 = 1'b0;
   logic       bD10 = 1'b0, bD12 = 1'b0, bD20 = 1'b0;
   logic       sw = 1'b0;
   logic [4:0] roll_value, roll_die;
   logic       roll_valid, busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   roll_generator #(
      .DEBOUNCE_CYCLES (DEB),
      .LFSR_SEED       (16'hACE1),
      .MAX_TRIES       (TRIES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .buttonD4   (bD4),
      .buttonD6   (bD6),
      .buttonD8   (bD8),
      .buttonD10  (bD10),
      .buttonD12  (bD12),
      .buttonD20  (bD20),
      .switchTest (sw),
      .roll_value (roll_value),
      .roll_die   (roll_die),
      .roll_valid (roll_valid),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // idx = edge index (0 = first edge after the call) where roll_valid is seen, -1 if never.
   task automatic wait_valid(input int limit, output int idx);
      idx = -1;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (roll_valid) begin
            idx = i;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int limit, output int ok, output int nvalid);
      ok = 0;
      nvalid = 0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (roll_valid) nvalid++;
         if (!busy) begin
            ok = 1;
            break;
         end
      end
   endtask

   int         nv, nb, idx, ok, first, distinct;
   logic [4:0] v, d;
   bit [31:0]  seen;

   initial begin
      // Reset and quiet idle period
      repeat (3) tick();
      check("rst_valid", roll_valid, 0);
      check("rst_value", roll_value, 0);
      check("rst_die", roll_die, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      nv = 0;
      nb = 0;
      repeat (100) begin
         tick();
         if (roll_valid) nv++;
         if (busy) nb++;
      end
      check("idle_valid_count", nv, 0);
      check("idle_busy_count", nb, 0);
      check("idle_value", roll_value, 0);

      // Test mode D6 held 40 cycles
      sw = 1'b1;
      repeat (3) tick();
      bD6 = 1'b1;
      nv = 0;
      first = -1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (roll_valid) begin
            nv++;
            if (first < 0) begin
               first = k;
               v = roll_value;
               d = roll_die;
            end
         end
      end
      check("d6_count", nv, 1);
      check("d6_latency", first, DEB + 3);
      check("d6_value", v, 6);
      check("d6_die", d, 6);
      bD6 = 1'b0;
      wait_idle(100, ok, nv);
      check("d6_release_idle", ok, 1);
      check("d6_release_no_roll", nv, 0);
      check("d6_hold_value", roll_value, 6);

      // D4 bounce: 5 cycles high then low
      bD4 = 1'b1;
      repeat (5) tick();
      check("bounce_busy", busy, 1);
      bD4 = 1'b0;
      nv = 0;
      repeat (30) begin
         tick();
         if (roll_valid) nv++;
      end
      check("bounce_no_roll", nv, 0);
      check("bounce_idle", busy, 0);
      check("bounce_hold_value", roll_value, 6);

      // D20 and D8 together: D8 wins, held D20 ignored during RELEASE
      bD20 = 1'b1;
      bD8  = 1'b1;
      wait_valid(40, idx);
      check("prio_latency", idx, DEB + 3);
      check("prio_die", roll_die, 8);
      check("prio_value", roll_value, 8);
      bD8 = 1'b0;
      wait_idle(100, ok, nv);
      check("prio_release_idle", ok, 1);
      check("prio_no_second_roll", nv, 0);
      bD20 = 1'b0;
      nv = 0;
      repeat (30) begin
         tick();
         if (roll_valid) nv++;
      end
      check("prio_after_no_roll", nv, 0);
      check("prio_after_idle", busy, 0);

      // 1000 random D20 rolls
      sw = 1'b0;
      repeat (3) tick();
      seen = '0;
      for (int r = 0; r < 1000; r++) begin
         bD20 = 1'b1;
         wait_valid(DEB + TRIES + 8, idx);
         check("d20_latency_ok", 32'((idx >= DEB + 3) && (idx <= DEB + 2 + TRIES)), 1);
         check("d20_range", 32'((roll_value >= 5'd1) && (roll_value <= 5'd20)), 1);
         check("d20_die", roll_die, 20);
         if (roll_value >= 5'd1 && roll_value <= 5'd20) seen[roll_value] = 1'b1;
         bD20 = 1'b0;
         wait_idle(100, ok, nv);
         check("d20_release", 32'(ok == 1 && nv == 0), 1);
      end
      distinct = 0;
      for (int i = 1; i <= 20; i++) if (seen[i]) distinct++;
      check("d20_all_values", distinct, 20);

      // Reset pulsed while in ROLL (test mode makes ROLL last exactly one cycle)
      sw = 1'b1;
      repeat (3) tick();
      bD12 = 1'b1;
      repeat (DEB + 3) tick();
      check("abort_pre_busy", busy, 1);
      reset = 1'b1;
      tick();
      check("abort_valid", roll_valid, 0);
      check("abort_value", roll_value, 0);
      check("abort_die", roll_die, 0);
      check("abort_busy", busy, 0);
      reset = 1'b0;
      bD12 = 1'b0;
      nv = 0;
      repeat (10) begin
         tick();
         if (roll_valid) nv++;
      end
      check("abort_no_roll", nv, 0);
      bD12 = 1'b1;
      wait_valid(40, idx);
      check("abort_next_latency", idx, DEB + 3);
      check("abort_next_value", roll_value, 12);
      check("abort_next_die", roll_die, 12);
      bD12 = 1'b0;
      wait_idle(100, ok, nv);
      check("abort_next_release", 32'(ok == 1 && nv == 0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
